// File: rtl/dram_init_wb_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_init_wb_master_pkg
// Purpose  : DRAM register map, PHY_READY field positions and sequencer states
// Revision : 1.0 - initial release
// ============================================================================
package dram_init_wb_master_pkg;

  localparam logic [2:0] c_REG_PHY_READY = 3'd0;
  localparam logic [2:0] c_REG_RESET     = 3'd1;
  localparam logic [2:0] c_REG_FREQ      = 3'd2;
  localparam logic [2:0] c_REG_GRANT     = 3'd3;

  localparam int c_PHY_READY_BIT = 0;
  localparam int c_PHY_CAL_BIT   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_RST = 3'd1,
    ST_GAP    = 3'd2,
    ST_RD_RDY = 3'd3,
    ST_RD_FRQ = 3'd4,
    ST_WR_GNT = 3'd5,
    ST_FIN    = 3'd6
  } state_t;

  // Registers sit on 16-bit lanes, so the index lands on byte-address bits [3:1].
  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [2:0] idx);
    return base + {28'd0, idx, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dram_init_wb_master_xfer.sv
`default_nettype none
// ============================================================================
// Module   : dram_init_wb_master_xfer
// Purpose  : Single Wishbone transaction engine; define DRAM_INIT_ACK_TIMEOUT_EN
//            to abandon a cycle that is not acked within 1023 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module dram_init_wb_master_xfer #(
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [15:0] wdat,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i
);

  logic        r_cyc;
  logic        r_we;
  logic [31:0] r_adr;
  logic [15:0] r_dat;
  logic [15:0] r_rdata;
  logic        r_ack;

`ifdef DRAM_INIT_ACK_TIMEOUT_EN
  // Counter is zero in the first cyc cycle, so this limit abandons after 1023 cycles.
  localparam logic [9:0] c_WDOG_LAST = 10'd1022;
  logic [9:0] r_wdog;
  logic       r_err;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= BASE_ADDR;
      r_dat   <= 16'h0000;
      r_rdata <= 16'h0000;
      r_ack   <= 1'b0;
`ifdef DRAM_INIT_ACK_TIMEOUT_EN
      r_wdog  <= 10'd0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
`ifdef DRAM_INIT_ACK_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      if (r_cyc) begin
        if (wb_ack_i) begin
          r_cyc   <= 1'b0;
          r_we    <= 1'b0;
          r_rdata <= wb_dat_i;
          r_ack   <= 1'b1;
        end
`ifdef DRAM_INIT_ACK_TIMEOUT_EN
        else if (r_wdog == c_WDOG_LAST) begin
          r_cyc <= 1'b0;
          r_we  <= 1'b0;
          r_err <= 1'b1;
        end else begin
          r_wdog <= r_wdog + 10'd1;
        end
`endif
      end else if (req) begin
        r_cyc  <= 1'b1;
        r_we   <= we;
        r_adr  <= adr;
        r_dat  <= wdat;
`ifdef DRAM_INIT_ACK_TIMEOUT_EN
        r_wdog <= 10'd0;
`endif
      end
    end
  end

  assign busy     = r_cyc;
  assign ack      = r_ack;
  assign rdata    = r_rdata;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_cyc;
  assign wb_we_o  = r_we;
  assign wb_sel_o = {2{r_cyc}};
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;

`ifdef DRAM_INIT_ACK_TIMEOUT_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/dram_init_wb_master.sv
`default_nettype none
// ============================================================================
// Module   : dram_init_wb_master
// Purpose  : Wishbone initiator sequencing DRAM reset, PHY-ready poll, FREQ read
//            and arbiter grant. Option macro: DRAM_INIT_ACK_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dram_init_wb_master
  import dram_init_wb_master_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          POLL_GAP  = 16,
  parameter int          POLL_MAX  = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy,
  output logic        done,
  output logic        cal_fail,
  output logic        timeout,
  output logic [15:0] dram_freq
);

  localparam logic [15:0] c_GAP_LOAD = 16'(POLL_GAP - 1);
  localparam logic [15:0] c_POLL_MAX = 16'(POLL_MAX);

  state_t      r_state;
  logic        r_req;
  logic        r_we;
  logic [2:0]  r_idx;
  logic [15:0] r_wdat;
  logic [15:0] r_gap_cnt;
  logic [15:0] r_poll_cnt;
  logic [15:0] r_dram_freq;
  logic        r_done;
  logic        r_cal_fail;
  logic        r_timeout;

  logic        w_xfer_busy;
  logic        w_xfer_ack;
  logic        w_xfer_err;
  logic [15:0] w_xfer_rdata;
  logic [15:0] w_poll_next;
  logic [31:0] w_xfer_adr;

  assign w_poll_next = r_poll_cnt + 16'd1;
  assign w_xfer_adr  = reg_addr(BASE_ADDR, r_idx);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_idx       <= 3'd0;
      r_wdat      <= 16'h0000;
      r_gap_cnt   <= 16'h0000;
      r_poll_cnt  <= 16'h0000;
      r_dram_freq <= 16'h0000;
      r_done      <= 1'b0;
      r_cal_fail  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_req  <= 1'b0;
      r_done <= 1'b0;
      if (w_xfer_err) begin
        // Abandoned bus cycle: report as timeout and finish without granting.
        r_timeout <= 1'b1;
        r_done    <= 1'b1;
        r_state   <= ST_FIN;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_cal_fail <= 1'b0;
              r_timeout  <= 1'b0;
              r_poll_cnt <= 16'h0000;
              r_req      <= 1'b1;
              r_we       <= 1'b1;
              r_idx      <= c_REG_RESET;
              r_wdat     <= 16'h0001;
              r_state    <= ST_WR_RST;
            end
          end
          ST_WR_RST: begin
            if (w_xfer_ack) begin
              r_gap_cnt <= c_GAP_LOAD;
              r_state   <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (r_gap_cnt == 16'h0000) begin
              r_req   <= 1'b1;
              r_we    <= 1'b0;
              r_idx   <= c_REG_PHY_READY;
              r_state <= ST_RD_RDY;
            end else begin
              r_gap_cnt <= r_gap_cnt - 16'd1;
            end
          end
          ST_RD_RDY: begin
            if (w_xfer_ack) begin
              r_poll_cnt <= w_poll_next;
              if (w_xfer_rdata[c_PHY_CAL_BIT]) begin
                r_cal_fail <= 1'b1;
                r_done     <= 1'b1;
                r_state    <= ST_FIN;
              end else if (w_xfer_rdata[c_PHY_READY_BIT]) begin
                r_req   <= 1'b1;
                r_we    <= 1'b0;
                r_idx   <= c_REG_FREQ;
                r_state <= ST_RD_FRQ;
              end else if (w_poll_next == c_POLL_MAX) begin
                r_timeout <= 1'b1;
                r_done    <= 1'b1;
                r_state   <= ST_FIN;
              end else begin
                r_gap_cnt <= c_GAP_LOAD;
                r_state   <= ST_GAP;
              end
            end
          end
          ST_RD_FRQ: begin
            if (w_xfer_ack) begin
              r_dram_freq <= w_xfer_rdata;
              r_req       <= 1'b1;
              r_we        <= 1'b1;
              r_idx       <= c_REG_GRANT;
              r_wdat      <= 16'h0001;
              r_state     <= ST_WR_GNT;
            end
          end
          ST_WR_GNT: begin
            if (w_xfer_ack) begin
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end
          end
          ST_FIN:  r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  dram_init_wb_master_xfer #(
    .BASE_ADDR (BASE_ADDR)
  ) u_xfer (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .req      (r_req),
    .we       (r_we),
    .adr      (w_xfer_adr),
    .wdat     (r_wdat),
    .busy     (w_xfer_busy),
    .ack      (w_xfer_ack),
    .err      (w_xfer_err),
    .rdata    (w_xfer_rdata),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_sel_o (wb_sel_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  assign busy      = (r_state != ST_IDLE) || w_xfer_busy;
  assign done      = r_done;
  assign cal_fail  = r_cal_fail;
  assign timeout   = r_timeout;
  assign dram_freq = r_dram_freq;

endmodule
`default_nettype wire

// File: doc/dram_init_wb_master.md
Name: dram_init_wb_master

Overview:
- Wishbone initiator that runs the DRAM bring-up sequence against the DRAM register slave: pulse DRAM reset, poll PHY-ready/cal-fail, read clock frequency, then grant the arbiter.
- Sits on the 16-bit Wishbone bus, driven by a board-control start strobe.
- Frees the CPU from hand-sequencing DRAM init.

Parameters:
- BASE_ADDR, 32'h0, byte base address of the DRAM register slave.
- POLL_GAP, 16, idle cycles between successive PHY_READY reads (min 1).
- POLL_MAX, 1024, maximum PHY_READY reads before timeout (min 1).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle request; ignored unless state IDLE.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  2  byte selects; always 2'b11 during a cycle.
- wb_adr_o  out  32  BASE_ADDR + {reg_index, 1'b0}.
- wb_dat_o  out  16  write data.
- wb_dat_i  in  16  read data, sampled on the ack cycle.
- wb_ack_i  in  1  slave acknowledge.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on sequence completion (success or failure).
- cal_fail  out  1  sticky; slave reported calibration failure.
- timeout  out  1  sticky; PHY never ready within POLL_MAX reads.
- dram_freq  out  16  last FREQ value read.

Behaviour:
- Register indices (wb_adr_o[3:1]): PHY_READY=0, RESET=1, FREQ=2, GRANT=3.
- Read data fields: PHY_READY bit0 = phy_ready, bit4 = cal_fail. RESET and GRANT use bit0.
- Reset values: all outputs 0; wb_adr_o = BASE_ADDR; state IDLE.
- Bus handshake:
  - State entry asserts cyc/stb (with we/adr/dat) on the next edge.
  - Outputs are held stable until the first cycle with wb_ack_i=1.
  - On that edge: cyc/stb/we drop to 0 and read data is captured.
  - Back-to-back cycles must have at least one idle cycle between them.
  - wb_ack_i while cyc=0 is ignored.
- FSM:
  - IDLE: start -> WR_RST.
  - WR_RST: write RESET=16'h0001; ack -> GAP.
  - GAP: wait POLL_GAP cycles -> RD_RDY.
  - RD_RDY: read PHY_READY; on ack:
    - bit4=1 -> set cal_fail, -> FIN.
    - else bit0=1 -> RD_FRQ.
    - else if poll count == POLL_MAX -> set timeout, -> FIN.
    - else -> GAP.
  - RD_FRQ: read FREQ; ack -> latch dram_freq -> WR_GNT.
  - WR_GNT: write GRANT=16'h0001; ack -> FIN.
  - FIN: done=1 for one cycle -> IDLE.
  - On failure, GRANT is never written.
- Poll count: 16-bit counter, cleared on WR_RST entry, incremented on each PHY_READY ack. Exactly POLL_MAX reads are issued before timeout.
- Simultaneous bit0 and bit4: cal_fail wins.
- Sticky flags: cal_fail and timeout clear only on reset or on an accepted start. dram_freq holds until the next successful FREQ read.
- start while busy: ignored; no queuing.
- Reset mid-transaction: cyc/stb drop asynchronously; no completion is issued.
- Latency, zero-wait slave (ack one cycle after stb), POLL_GAP=16, ready on the first read: done asserts a fixed cycle count after start. The bench measures it and it must not change between runs.

Optional Feature:
- Macro: DRAM_INIT_ACK_TIMEOUT_EN.
- With it: a 10-bit watchdog counts cycles while cyc_o=1 without ack. At 1023 the cycle is abandoned (cyc/stb drop), timeout is set, and the FSM goes to FIN.
- Without it: the block waits for ack indefinitely.

Decomposition:
- Shared header dram_cpu_interface.vh holds:
  - the four register index defines;
  - PHY_READY field bit positions (READY=0, CAL_FAIL=4);
  - FSM state encodings.
- One sub-module, wb_master_xfer: single-transaction engine (req/we/adr/dat in; busy/ack/rdata out). The FSM sequences calls to it.

Test Plan:
- Zero-wait slave, phy_ready rises after 3 reads, FREQ=16'd200:
  - bus order is W RESET=1, R PHY_READY x3, R FREQ, W GRANT=1;
  - done pulses once; dram_freq=200; cal_fail=timeout=0.
- Slave returns PHY_READY=16'h0010 on the second read: cal_fail=1, no FREQ/GRANT access, done pulses.
- phy_ready never set, POLL_MAX=4: exactly 4 PHY_READY reads; timeout=1; no GRANT write.
- Slave with 5-cycle ack delay: stb/adr/dat held constant through the wait; exactly one access per state.
- Assert wb_rst_i during RD_RDY: cyc/stb go low in the same cycle; busy=0.
  - After release, a new start runs the full sequence; a start pulsed while busy is ignored.
- With DRAM_INIT_ACK_TIMEOUT_EN and a slave that never acks: cyc drops after 1023 cycles; timeout=1; done pulses.
